// File: rtl/version_reporter.sv
// Streams the build-identification constants as a 13-byte framed record
// (SYNC, version, BCD timestamp, XOR checksum) over a byte-wide valid/ready stream.
module version_reporter #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned REPEAT_PERIOD = 0,
  parameter logic [7:0]  MAJOR         = 8'h00,
  parameter logic [7:0]  MINOR         = 8'h00,
  parameter logic [7:0]  PATCH         = 8'h00,
  parameter logic [7:0]  BUILD         = 8'h2E,
  parameter logic [15:0] YEAR          = 16'h2025,
  parameter logic [7:0]  MONTH         = 8'h11,
  parameter logic [7:0]  DAY           = 8'h04,
  parameter logic [7:0]  HOUR          = 8'h17,
  parameter logic [7:0]  MINUTE        = 8'h54,
  parameter logic [7:0]  SECOND        = 8'h28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic [15:0] frames_sent_o
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  data_q, data_d;
  logic        pending_q, pending_d;
  logic [15:0] frames_sent_q;
  logic        timer_hit;
  logic        start;
  logic        frame_done;

  // Payload bytes 0..11; the checksum byte comes from the accumulator instead.
  function automatic logic [7:0] field_byte(input logic [3:0] i);
    case (i)
      4'd0:    field_byte = SYNC_BYTE;
      4'd1:    field_byte = MAJOR;
      4'd2:    field_byte = MINOR;
      4'd3:    field_byte = PATCH;
      4'd4:    field_byte = BUILD;
      4'd5:    field_byte = YEAR[15:8];
      4'd6:    field_byte = YEAR[7:0];
      4'd7:    field_byte = MONTH;
      4'd8:    field_byte = DAY;
      4'd9:    field_byte = HOUR;
      4'd10:   field_byte = MINUTE;
      4'd11:   field_byte = SECOND;
      default: field_byte = 8'h00;
    endcase
  endfunction

  generate
    if (REPEAT_PERIOD == 0) begin : g_no_timer
      assign timer_hit = 1'b0;
    end else begin : g_timer
      logic [31:0] timer_q;
      assign timer_hit = (timer_q == 32'(REPEAT_PERIOD - 1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer_q <= '0;
        end else if (timer_hit) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    data_d     = data_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
    start      = req_i || pending_q || timer_hit;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSend;
          idx_d     = 4'd0;
          chk_d     = 8'h00;
          data_d    = SYNC_BYTE;
          pending_d = 1'b0;
        end
      end
      StSend: begin
        if (req_i || timer_hit) pending_d = 1'b1;
        if (tx_ready_i) begin
          if (idx_q == 4'd12) begin
            state_d    = StIdle;
            idx_d      = 4'd0;
            data_d     = 8'h00;
            frame_done = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q != 4'd0) chk_d = chk_q ^ field_byte(idx_q);
            // Byte 12 is the checksum including the byte just accepted.
            data_d = (idx_q == 4'd11) ? chk_d : field_byte(idx_d);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      chk_q     <= 8'h00;
      data_q    <= 8'h00;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent_q <= 16'h0000;
    end else if (frame_done) begin
      frames_sent_q <= frames_sent_q + 16'd1;
    end
  end

  assign tx_valid_o    = (state_q == StSend);
  assign busy_o        = (state_q == StSend);
  assign tx_data_o     = data_q;
  assign frames_sent_o = frames_sent_q;

endmodule

// File: tb/tb_version_reporter.sv
// Scoreboard bench for version_reporter: stimulus queues expected bytes, monitors
// pop and compare on every accepted byte; a second instance exercises the period timer.
module tb_version_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [15:0] frames;

  logic [7:0]  t_data;
  logic        t_valid;
  logic        t_busy;
  logic [15:0] t_frames;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;

  logic [7:0] ref_frame [13];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  version_reporter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (ready),
    .busy_o       (busy),
    .frames_sent_o(frames)
  );

  version_reporter #(.REPEAT_PERIOD(100)) dut_t (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (1'b0),
    .tx_data_o    (t_data),
    .tx_valid_o   (t_valid),
    .tx_ready_i   (1'b1),
    .busy_o       (t_busy),
    .frames_sent_o(t_frames)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 13; i++) exp_q.push_back(ref_frame[i]);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Two frames expected with exactly one idle cycle; extra requests at sample a/b/c.
  task automatic run_pattern(input int a, input int b, input int c, input string name);
    int  bad;
    logic exp_v;
    bad = 0;
    push_frame();
    push_frame();
    ready = 1'b1;
    pulse_req();
    for (int i = 0; i < 40; i++) begin
      exp_v = (i < 13) || (i >= 14 && i < 27);
      if (tx_valid !== exp_v) bad++;
      req = (i == a) || (i == b) || (i == c);
      tick();
    end
    req = 1'b0;
    exp_frames += 2;
    check({name, " valid pattern errors"}, bad, 0);
    check({name, " frames_sent"}, frames, exp_frames);
  endtask

  // Main monitor: accepted bytes against the scoreboard, hold stability under backpressure.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold valid", tx_valid, 1);
        check("hold data", tx_data, prev_data);
      end
      if (tx_valid && ready) begin
        if (exp_q.size() == 0) check("unexpected byte", tx_data, 32'hFFFF_FFFF);
        else check("stream byte", tx_data, exp_q.pop_front());
      end
      prev_hold = tx_valid && !ready;
      prev_data = tx_data;
    end
  end

  // Timer monitor: frame starts spaced by the period, checksum correct each frame.
  int cyc = 0;
  int last_sync = -1;
  int t_idx = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_sync = -1;
      t_idx = 0;
    end else if (t_valid) begin
      if (t_idx == 0) begin
        check("timer sync", t_data, ref_frame[0]);
        if (last_sync >= 0) check("timer spacing", cyc - last_sync, 100);
        last_sync = cyc;
      end
      if (t_idx == 12) check("timer chk", t_data, ref_frame[12]);
      t_idx = (t_idx + 1) % 13;
    end
  end

  initial begin
    int cnt;
    int guard;
    ref_frame[0]  = 8'hA5;
    ref_frame[1]  = 8'h00;
    ref_frame[2]  = 8'h00;
    ref_frame[3]  = 8'h00;
    ref_frame[4]  = 8'h2E;
    ref_frame[5]  = 8'h20;
    ref_frame[6]  = 8'h25;
    ref_frame[7]  = 8'h11;
    ref_frame[8]  = 8'h04;
    ref_frame[9]  = 8'h17;
    ref_frame[10] = 8'h54;
    ref_frame[11] = 8'h28;
    ref_frame[12] = 8'h00;
    for (int i = 1; i < 12; i++) ref_frame[12] = ref_frame[12] ^ ref_frame[i];

    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset valid", tx_valid, 0);
    check("reset data", tx_data, 0);
    check("reset busy", busy, 0);
    check("reset frames", frames, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle valid", tx_valid, 0);

    // Single request, ready held high
    ready = 1'b1;
    push_frame();
    pulse_req();
    check("latency valid", tx_valid, 1);
    check("latency sync", tx_data, ref_frame[0]);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) cnt++;
      tick();
    end
    exp_frames++;
    check("busy cycles", cnt, 13);
    check("frames after one", frames, exp_frames);
    check("queue drained 1", exp_q.size(), 0);

    // Random backpressure at ~30% ready
    push_frame();
    exp_frames++;
    ready = ($urandom_range(0, 99) < 30);
    pulse_req();
    guard = 0;
    while (frames != 16'(exp_frames) && guard < 400) begin
      ready = ($urandom_range(0, 99) < 30);
      tick();
      guard++;
    end
    ready = 1'b1;
    tick();
    check("frames after backpressure", frames, exp_frames);
    check("queue drained 2", exp_q.size(), 0);

    // Requests during a frame, and on the final-byte edge
    run_pattern(3, 7, 10, "three reqs");
    run_pattern(12, -1, -1, "req on last byte");
    check("queue drained 3", exp_q.size(), 0);

    // Asynchronous reset mid-frame
    push_frame();
    pulse_req();
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midreset valid", tx_valid, 0);
    check("midreset data", tx_data, 0);
    check("midreset busy", busy, 0);
    check("midreset frames", frames, 0);
    exp_q.delete();
    exp_frames = 0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) cnt++;
      tick();
    end
    check("no frame after reset", cnt, 0);
    push_frame();
    pulse_req();
    check("post reset sync", tx_data, ref_frame[0]);
    for (int i = 0; i < 20; i++) tick();
    exp_frames++;
    check("frames after reset", frames, exp_frames);
    check("queue drained 4", exp_q.size(), 0);

    // Frame counter wrap
    force dut.frames_sent_q = 16'hFFFF;
    tick();
    release dut.frames_sent_q;
    tick();
    check("preload frames", frames, 16'hFFFF);
    push_frame();
    pulse_req();
    for (int i = 0; i < 20; i++) tick();
    check("frames wrap", frames, 0);
    check("queue drained 5", exp_q.size(), 0);

    // Let the timer instance run several periods
    for (int i = 0; i < 250; i++) tick();
    check("timer frames seen", (t_frames >= 16'd2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
